bus_slave_ctrl: RTL and testbench

BUS_SLAVE_CTRL -- requirements
Module: bus_slave_ctrl

---
 rtl/bus_pkg.sv | 20 ++
 rtl/bus_parity_gen.sv | 22 ++
 rtl/bus_slave_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_bus_slave_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared types and helpers for the bus slave controller.
package bus_pkg;

  // Transaction sequencing states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    ACK     = 2'd2,
    RELEASE = 2'd3
  } state_t;

  // Widest data word the parity helper accepts
  localparam int PAR_MAX_W = 64;

  // Parity over a zero-extended word; zero padding does not change the XOR.
  function automatic logic parity_calc(input logic [PAR_MAX_W-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

endpackage

// File: rtl/bus_parity_gen.sv
// Combinational parity generator, used both to check write data and to
// produce the parity bit that accompanies read data.
module bus_parity_gen
  import bus_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int PARITY_ODD = 0
) (
  input  logic [WIDTH-1:0] data,
  output logic             parity
);

  logic [PAR_MAX_W-1:0] ext;

  // Zero-extend to the helper width and fold to a single parity bit
  always_comb begin
    ext              = '0;
    ext[WIDTH-1:0]   = data;
    parity           = parity_calc(ext, PARITY_ODD != 0);
  end

endmodule

// File: rtl/bus_slave_ctrl.sv
// Strobe-driven register slave: decodes a window of NUM_REGS registers at
// BASE_ADDR, inserts WAIT_STATES before acknowledging, checks write parity
// and returns read data with generated parity.
module bus_slave_ctrl
  import bus_pkg::*;
#(
  parameter int BUS_WIDTH   = 8,
  parameter int NUM_REGS    = 4,
  parameter int BASE_ADDR   = 'h10,
  parameter int WAIT_STATES = 1,
  parameter int PARITY_ODD  = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rb_n,
  input  logic                          wb_n,
  input  logic [7:0]                    address,
  input  logic [BUS_WIDTH-1:0]          data_in,
  input  logic                          parity_in,
  output logic [BUS_WIDTH-1:0]          data_out,
  output logic                          parity_out,
  output logic                          data_oe,
  output logic                          ack_n,
  input  logic                          err_clr,
  output logic                          parity_err,
  output logic [NUM_REGS*BUS_WIDTH-1:0] reg_q
);

  localparam int         IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [8:0] BASE9  = 9'(BASE_ADDR);
  localparam logic [8:0] LIMIT9 = 9'(BASE_ADDR + NUM_REGS);

  // The register window must fit inside the 8-bit address space
  if (BASE_ADDR + NUM_REGS > 256) begin : g_bad_map
    $error("bus_slave_ctrl: BASE_ADDR + NUM_REGS exceeds the 8-bit address space");
  end

  state_t                 state, nstate;
  logic [3:0]             cnt, ncnt;
  logic                   rd_req, wr_req, one_req, hit, held;
  logic [IDX_W-1:0]       live_idx, cap_idx, acc_idx;
  logic [BUS_WIDTH-1:0]   cap_data, acc_data, rd_data;
  logic                   cap_par, cap_wr, acc_par, acc_wr;
  logic                   do_acc, chk_par, rd_par, par_ok, wr_en, perr_set, drive_rd;
  logic [BUS_WIDTH-1:0]   regs [NUM_REGS];

  assign rd_req   = ~rb_n;
  assign wr_req   = ~wb_n;
  assign one_req  = rd_req ^ wr_req;
  assign hit      = ({1'b0, address} >= BASE9) && ({1'b0, address} < LIMIT9);
  assign live_idx = IDX_W'(address - 8'(BASE_ADDR));
  // Only the strobe that started the transaction keeps it alive
  assign held     = cap_wr ? wr_req : rd_req;

  // Access operands: live bus in IDLE (zero-wait path), captured copy otherwise
  always_comb begin
    if (state == IDLE) begin
      acc_idx  = live_idx;
      acc_data = data_in;
      acc_par  = parity_in;
      acc_wr   = wr_req;
    end else begin
      acc_idx  = cap_idx;
      acc_data = cap_data;
      acc_par  = cap_par;
      acc_wr   = cap_wr;
    end
  end

  bus_parity_gen #(.WIDTH(BUS_WIDTH), .PARITY_ODD(PARITY_ODD)) u_chk (
    .data   (acc_data),
    .parity (chk_par)
  );

  // Next-state logic; do_acc marks the edge that enters ACK
  always_comb begin
    nstate = state;
    ncnt   = cnt;
    do_acc = 1'b0;
    case (state)
      IDLE: begin
        if (rd_req && wr_req) begin
          nstate = RELEASE;
        end else if (one_req) begin
          if (!hit) begin
            nstate = RELEASE;
          end else if (WAIT_STATES > 0) begin
            nstate = WAIT;
            ncnt   = 4'(WAIT_STATES - 1);
          end else begin
            nstate = ACK;
            do_acc = 1'b1;
          end
        end
      end
      WAIT: begin
        if (!held) begin
          nstate = IDLE;
          ncnt   = 4'd0;
        end else if (cnt == 4'd0) begin
          nstate = ACK;
          do_acc = 1'b1;
        end else begin
          ncnt = cnt - 4'd1;
        end
      end
      ACK: begin
        if (!held) nstate = IDLE;
      end
      RELEASE: begin
        if (rb_n && wb_n) nstate = IDLE;
      end
      default: nstate = IDLE;
    endcase
  end

  assign par_ok   = (acc_par == chk_par);
  assign wr_en    = do_acc && acc_wr && par_ok;
  assign perr_set = do_acc && acc_wr && !par_ok;

  // State and wait counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= nstate;
      cnt   <= ncnt;
    end
  end

  // Capture the request on the edge that leaves IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_idx  <= '0;
      cap_data <= '0;
      cap_par  <= 1'b0;
      cap_wr   <= 1'b0;
    end else if (state == IDLE && nstate != IDLE) begin
      cap_idx  <= live_idx;
      cap_data <= data_in;
      cap_par  <= parity_in;
      cap_wr   <= wr_req;
    end
  end

  // Register file write on entry to ACK with good parity
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_en && acc_idx == IDX_W'(i)) regs[i] <= acc_data;
      end
    end
  end

  // Sticky parity error; a new error outranks a clear on the same edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_err <= 1'b0;
    end else if (perr_set) begin
      parity_err <= 1'b1;
    end else if (err_clr) begin
      parity_err <= 1'b0;
    end
  end

  // Read mux over the captured index, bounded to existing registers
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (cap_idx == IDX_W'(i)) rd_data = regs[i];
    end
  end

  bus_parity_gen #(.WIDTH(BUS_WIDTH), .PARITY_ODD(PARITY_ODD)) u_gen (
    .data   (rd_data),
    .parity (rd_par)
  );

  assign drive_rd = (state == ACK) && held && !cap_wr;

  // Registered bus outputs: one cycle behind ACK entry, drop with the strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_n      <= 1'b1;
      data_oe    <= 1'b0;
      data_out   <= '0;
      parity_out <= 1'b0;
    end else begin
      ack_n      <= !((state == ACK) && held);
      data_oe    <= drive_rd;
      data_out   <= drive_rd ? rd_data : '0;
      parity_out <= drive_rd ? rd_par : 1'b0;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regq
    assign reg_q[g*BUS_WIDTH +: BUS_WIDTH] = regs[g];
  end

endmodule

// File: tb/tb_bus_slave_ctrl.sv
// Bench for bus_slave_ctrl: table-driven vectors, hand sequences for reset
// and zero-wait/odd-parity configuration, and a randomized transaction run
// checked cycle by cycle against a transaction-level model.
module tb_bus_slave_ctrl;

  localparam int WS_A = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DUT A: 8-bit, one wait state, even parity
  logic        rb_n = 1'b1, wb_n = 1'b1, parity_in = 1'b0, err_clr = 1'b0;
  logic [7:0]  address = 8'h00, data_in = 8'h00;
  logic [7:0]  data_out;
  logic        parity_out, data_oe, ack_n, parity_err;
  logic [31:0] reg_q;

  // DUT B: 16-bit, no wait states, odd parity
  logic        rb_nb = 1'b1, wb_nb = 1'b1, pinb = 1'b0, err_clrb = 1'b0;
  logic [7:0]  addrb = 8'h00;
  logic [15:0] dinb = 16'h0000;
  logic [15:0] doutb;
  logic        poutb, oeb, ackb, perrb;
  logic [63:0] reg_qb;

  bus_slave_ctrl #(.BUS_WIDTH(8), .NUM_REGS(4), .BASE_ADDR('h10),
                   .WAIT_STATES(WS_A), .PARITY_ODD(0)) dut_a (
    .clk(clk), .rst(rst), .rb_n(rb_n), .wb_n(wb_n), .address(address),
    .data_in(data_in), .parity_in(parity_in), .data_out(data_out),
    .parity_out(parity_out), .data_oe(data_oe), .ack_n(ack_n),
    .err_clr(err_clr), .parity_err(parity_err), .reg_q(reg_q)
  );

  bus_slave_ctrl #(.BUS_WIDTH(16), .NUM_REGS(4), .BASE_ADDR('h10),
                   .WAIT_STATES(0), .PARITY_ODD(1)) dut_b (
    .clk(clk), .rst(rst), .rb_n(rb_nb), .wb_n(wb_nb), .address(addrb),
    .data_in(dinb), .parity_in(pinb), .data_out(doutb),
    .parity_out(poutb), .data_oe(oeb), .ack_n(ackb),
    .err_clr(err_clrb), .parity_err(perrb), .reg_q(reg_qb)
  );

  int n_cmp = 0;
  int n_mis = 0;

  // Transaction-level model of DUT A
  logic [7:0] ma [4];
  logic       merr;

  function automatic logic par_even(input logic [7:0] d);
    return 1'($countones(d) & 1);
  endfunction

  function automatic logic [31:0] mpack();
    return {ma[3], ma[2], ma[1], ma[0]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) ma[i] = 8'h00;
    merr = 1'b0;
  endtask

  // One transaction on DUT A; strobe held low for 'hold' clock edges.
  task automatic run_txn(input bit rd, input bit wr, input logic [7:0] ad,
                         input logic [7:0] dt, input logic pi, input int hold,
                         input bit rnd, output bit ack_seen, output int lat,
                         output logic [7:0] rdv, output logic rpv);
    bit  hit, acc, ack_exp, oe_exp, set;
    int  idx;
    hit = (ad >= 8'h10) && (ad < 8'h14);
    idx = int'(ad) - 'h10;
    acc = hit && (rd != wr) && (hold >= WS_A + 1);
    ack_seen = 1'b0; lat = -1; rdv = 8'h00; rpv = 1'b0;
    @(negedge clk);
    address = ad; data_in = dt; parity_in = pi;
    rb_n = !rd; wb_n = !wr;
    for (int k = 0; k < hold; k++) begin
      err_clr = rnd ? ($urandom_range(0, 7) == 0) : 1'b0;
      @(posedge clk);
      set = 1'b0;
      if (acc && wr && k == WS_A) begin
        if (pi == par_even(dt)) ma[idx] = dt;
        else set = 1'b1;
      end
      merr = set ? 1'b1 : (err_clr ? 1'b0 : merr);
      @(negedge clk);
      ack_exp = acc && (k >= WS_A + 1);
      oe_exp  = ack_exp && rd;
      chk("ack_n", ack_n, !ack_exp);
      chk("data_oe", data_oe, oe_exp);
      chk("data_out", data_out, oe_exp ? ma[idx] : 8'h00);
      chk("parity_out", parity_out, oe_exp ? par_even(ma[idx]) : 1'b0);
      chk("reg_q", reg_q, mpack());
      chk("parity_err", parity_err, merr);
      if (!ack_n && !ack_seen) begin
        ack_seen = 1'b1; lat = k; rdv = data_out; rpv = parity_out;
      end
      if (rnd) begin
        address = 8'($urandom); data_in = 8'($urandom); parity_in = 1'($urandom);
      end
    end
    rb_n = 1'b1; wb_n = 1'b1; err_clr = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("idle ack_n", ack_n, 1'b1);
    chk("idle data_oe", data_oe, 1'b0);
    chk("idle data_out", data_out, 8'h00);
  endtask

  typedef struct {
    bit         rd, wr;
    logic [7:0] ad, dt;
    logic       pi;
    int         hold;
    bit         clr;
    bit         e_ack;
    int         e_lat;
    logic [7:0] e_rd;
    logic       e_rp;
    logic       e_err;
    logic [31:0] e_reg;
  } vec_t;

  vec_t vecs [10];

  initial begin
    bit         seen;
    int         lat;
    logic [7:0] rdv;
    logic       rpv;

    vecs[0] = '{0, 1, 8'h11, 8'hA5, 1'b0, 4, 0, 1, 2, 8'h00, 1'b0, 1'b0, 32'h0000A500};
    vecs[1] = '{1, 0, 8'h11, 8'h00, 1'b0, 4, 0, 1, 2, 8'hA5, 1'b0, 1'b0, 32'h0000A500};
    vecs[2] = '{0, 1, 8'h10, 8'h01, 1'b0, 4, 0, 1, 2, 8'h00, 1'b0, 1'b1, 32'h0000A500};
    vecs[3] = '{1, 0, 8'h14, 8'h00, 1'b0, 4, 1, 0, 0, 8'h00, 1'b0, 1'b0, 32'h0000A500};
    vecs[4] = '{0, 1, 8'h14, 8'h33, 1'b0, 4, 0, 0, 0, 8'h00, 1'b0, 1'b0, 32'h0000A500};
    vecs[5] = '{1, 1, 8'h10, 8'h77, 1'b1, 4, 0, 0, 0, 8'h00, 1'b0, 1'b0, 32'h0000A500};
    vecs[6] = '{0, 1, 8'h13, 8'h5A, 1'b0, 4, 0, 1, 2, 8'h00, 1'b0, 1'b0, 32'h5A00A500};
    vecs[7] = '{0, 1, 8'h12, 8'h7F, 1'b1, 1, 0, 0, 0, 8'h00, 1'b0, 1'b0, 32'h5A00A500};
    vecs[8] = '{0, 1, 8'h12, 8'h7F, 1'b1, 3, 0, 1, 2, 8'h00, 1'b0, 1'b0, 32'h5A7FA500};
    vecs[9] = '{1, 0, 8'h13, 8'h00, 1'b0, 3, 0, 1, 2, 8'h5A, 1'b0, 1'b0, 32'h5A7FA500};

    model_reset();
    repeat (2) @(negedge clk);
    chk("rst ack_n", ack_n, 1'b1);
    chk("rst data_oe", data_oe, 1'b0);
    chk("rst data_out", data_out, 8'h00);
    chk("rst parity_out", parity_out, 1'b0);
    chk("rst parity_err", parity_err, 1'b0);
    chk("rst reg_q", reg_q, 32'h0);
    chk("rst b ack_n", ackb, 1'b1);
    chk("rst b reg_q", reg_qb, 64'h0);
    rst = 1'b0;

    // Directed vectors
    for (int v = 0; v < 10; v++) begin
      run_txn(vecs[v].rd, vecs[v].wr, vecs[v].ad, vecs[v].dt, vecs[v].pi,
              vecs[v].hold, 1'b0, seen, lat, rdv, rpv);
      if (vecs[v].clr) begin
        @(negedge clk); err_clr = 1'b1;
        @(posedge clk); merr = 1'b0;
        @(negedge clk); err_clr = 1'b0;
      end
      chk($sformatf("vec%0d ack_seen", v), seen, vecs[v].e_ack);
      if (vecs[v].e_ack) chk($sformatf("vec%0d latency", v), lat, vecs[v].e_lat);
      chk($sformatf("vec%0d rdata", v), rdv, vecs[v].e_rd);
      chk($sformatf("vec%0d rparity", v), rpv, vecs[v].e_rp);
      chk($sformatf("vec%0d parity_err", v), parity_err, vecs[v].e_err);
      chk($sformatf("vec%0d reg_q", v), reg_q, vecs[v].e_reg);
    end

    // Randomized transactions
    for (int t = 0; t < 300; t++) begin
      int         r;
      bit         rd, wr;
      logic [7:0] ad, dt;
      logic       pi;
      r  = $urandom_range(0, 9);
      rd = (r == 0) || (r >= 6);
      wr = (r <= 5);
      ad = 8'h0E + 8'($urandom_range(0, 7));
      dt = 8'($urandom);
      pi = ($urandom_range(0, 3) != 0) ? par_even(dt) : !par_even(dt);
      run_txn(rd, wr, ad, dt, pi, $urandom_range(1, 6), 1'b1, seen, lat, rdv, rpv);
    end

    // Reset while waiting, then a request already pending at reset release
    @(negedge clk);
    address = 8'h11; data_in = 8'hFF; parity_in = 1'b0; wb_n = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    model_reset();
    chk("wrst ack_n", ack_n, 1'b1);
    chk("wrst data_oe", data_oe, 1'b0);
    chk("wrst reg_q", reg_q, 32'h0);
    chk("wrst parity_err", parity_err, 1'b0);
    repeat (2) begin
      @(negedge clk);
      chk("wrst held ack_n", ack_n, 1'b1);
    end
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("rel e0 ack_n", ack_n, 1'b1);
    chk("rel e0 reg_q", reg_q, 32'h0);
    @(posedge clk); @(negedge clk);
    ma[1] = 8'hFF;
    chk("rel e1 ack_n", ack_n, 1'b1);
    chk("rel e1 reg_q", reg_q, mpack());
    @(posedge clk); @(negedge clk);
    chk("rel e2 ack_n", ack_n, 1'b0);
    wb_n = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("rel done ack_n", ack_n, 1'b1);

    // Zero-wait, 16-bit, odd parity instance
    @(negedge clk);
    addrb = 8'h13; dinb = 16'h0003; pinb = 1'b1; wb_nb = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("b wr e0 ack_n", ackb, 1'b1);
    @(posedge clk); @(negedge clk);
    chk("b wr e1 ack_n", ackb, 1'b0);
    chk("b wr reg_q", reg_qb, 64'h0003_0000_0000_0000);
    chk("b wr parity_err", perrb, 1'b0);
    wb_nb = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("b wr done ack_n", ackb, 1'b1);

    addrb = 8'h10; dinb = 16'h0003; pinb = 1'b0; wb_nb = 1'b0;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    chk("b bad ack_n", ackb, 1'b0);
    chk("b bad parity_err", perrb, 1'b1);
    chk("b bad reg_q", reg_qb, 64'h0003_0000_0000_0000);
    wb_nb = 1'b1;
    @(posedge clk); @(negedge clk);

    addrb = 8'h13; rb_nb = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("b rd e0 data_oe", oeb, 1'b0);
    @(posedge clk); @(negedge clk);
    chk("b rd ack_n", ackb, 1'b0);
    chk("b rd data_oe", oeb, 1'b1);
    chk("b rd data_out", doutb, 16'h0003);
    chk("b rd parity_out", poutb, 1'b1);
    rb_nb = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("b rd done data_oe", oeb, 1'b0);
    chk("b rd done data_out", doutb, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
